bat_amateur_alu_unit: RTL and testbench

- Datapath ALU that sits on the far end of the controller's ALU_EN/ALU_OP interface.
- Executes the op code the controller issues and drives the result onto the shared bus when enabled.
- Publishes the registered flag byte ALU_REG, which the controller samples into its zero/carry flags for conditional jumps.
- Single-cycle logic/arith ops, plus an iterative multiply with a busy handshake.

---
 rtl/bat_amateur_alu_pkg.sv | 45 ++++
 rtl/bat_amateur_alu_if.sv | 32 +++
 rtl/bat_amateur_alu_unit_seq_muldiv.sv | 127 ++++++++++++
 rtl/bat_amateur_alu_unit.sv | 189 ++++++++++++++++++
 tb/tb_bat_amateur_alu_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bat_amateur_alu_pkg.sv
// ============================================================================
// Module      : bat_amateur_alu_pkg
// Description : Op codes, flag bit positions and sequencer state encoding
//               shared by the ALU unit and its iterative multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bat_amateur_alu_pkg;

    localparam logic [4:0] C_OP_PASSA = 5'd0;
    localparam logic [4:0] C_OP_ADD   = 5'd1;
    localparam logic [4:0] C_OP_ADC   = 5'd2;
    localparam logic [4:0] C_OP_SUB   = 5'd3;
    localparam logic [4:0] C_OP_SBB   = 5'd4;
    localparam logic [4:0] C_OP_AND   = 5'd5;
    localparam logic [4:0] C_OP_OR    = 5'd6;
    localparam logic [4:0] C_OP_XOR   = 5'd7;
    localparam logic [4:0] C_OP_NOTA  = 5'd8;
    localparam logic [4:0] C_OP_INCA  = 5'd9;
    localparam logic [4:0] C_OP_DECA  = 5'd10;
    localparam logic [4:0] C_OP_SHL   = 5'd11;
    localparam logic [4:0] C_OP_SHR   = 5'd12;
    localparam logic [4:0] C_OP_ROL   = 5'd13;
    localparam logic [4:0] C_OP_ROR   = 5'd14;
    localparam logic [4:0] C_OP_CMP   = 5'd15;
    localparam logic [4:0] C_OP_MULLO = 5'd16;
    localparam logic [4:0] C_OP_MULHI = 5'd17;
    localparam logic [4:0] C_OP_DIV   = 5'd18;
    localparam logic [4:0] C_OP_MOD   = 5'd19;

    localparam int C_FLAG_Z    = 0;
    localparam int C_FLAG_C    = 1;
    localparam int C_FLAG_N    = 2;
    localparam int C_FLAG_V    = 3;
    localparam int C_FLAG_BUSY = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/bat_amateur_alu_if.sv
// ============================================================================
// Module      : bat_amateur_alu_if
// Description : Controller <-> ALU signal bundle (operands, op, strobes, bus,
//               flag byte and busy).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bat_amateur_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A_IN;
    logic [WIDTH-1:0] B_IN;
    logic [4:0]       ALU_OP;
    logic             ALU_GO;
    logic             ALU_EN;
    logic [WIDTH-1:0] BUS_OUT;
    logic [7:0]       ALU_REG;
    logic             ALU_BUSY;

    modport master (
        output A_IN, B_IN, ALU_OP, ALU_GO, ALU_EN,
        input  BUS_OUT, ALU_REG, ALU_BUSY
    );

    modport slave (
        input  A_IN, B_IN, ALU_OP, ALU_GO, ALU_EN,
        output BUS_OUT, ALU_REG, ALU_BUSY
    );
endinterface

`default_nettype wire

// File: rtl/bat_amateur_alu_unit_seq_muldiv.sv
// ============================================================================
// Module      : bat_amateur_seq_muldiv
// Description : Iterative shift-add multiplier, one bit per cycle; restoring
//               divider in the same engine when ALU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bat_amateur_seq_muldiv
    import bat_amateur_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [4:0]       op,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      lo,
    output logic [WIDTH-1:0]      hi
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [C_CNT_W-1:0] r_count;
    logic [C_CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0]   r_oper;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [WIDTH:0]     w_sum;
    logic               w_is_div;

`ifdef ALU_DIV_EN
    logic               r_div;
    logic [WIDTH:0]     w_shift;
    logic               w_fit;
    assign w_is_div = (op == C_OP_DIV) || (op == C_OP_MOD);
`else
    logic               w_unused_op;
    assign w_is_div    = 1'b0;
    assign w_unused_op = ^op;
`endif

    // {r_hi, r_lo} is the running product (multiplier shifts out of r_lo)
    // or the running remainder/quotient pair during division.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_sum       = '0;
`ifdef ALU_DIV_EN
        w_shift     = '0;
        w_fit       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ITER;
                    w_count_nxt = C_CNT_W'(WIDTH);
                    w_hi_nxt    = '0;
                    w_lo_nxt    = w_is_div ? a : b;
                end
            end
            ST_ITER: begin
`ifdef ALU_DIV_EN
                if (r_div) begin
                    w_shift  = {r_hi, r_lo[WIDTH-1]};
                    w_fit    = (w_shift >= {1'b0, r_oper});
                    w_hi_nxt = w_fit ? (w_shift[WIDTH-1:0] - r_oper) : w_shift[WIDTH-1:0];
                    w_lo_nxt = {r_lo[WIDTH-2:0], w_fit};
                end else
`endif
                begin
                    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_oper} : {(WIDTH+1){1'b0}});
                    {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[WIDTH-1:1]};
                end
                w_count_nxt = r_count - C_CNT_W'(1);
                if (r_count == C_CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_oper  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef ALU_DIV_EN
            r_div   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (start && (r_state == ST_IDLE)) begin
                r_oper <= w_is_div ? b : a;
`ifdef ALU_DIV_EN
                r_div  <= w_is_div;
`endif
            end
        end
    end

    // lo/hi present the post-step value so the parent can load it on the
    // same edge the engine returns to idle.
    assign busy = (r_state == ST_ITER);
    assign done = (r_state == ST_ITER) && (r_count == C_CNT_W'(1));
    assign lo   = w_lo_nxt;
    assign hi   = w_hi_nxt;

endmodule

`default_nettype wire

// File: rtl/bat_amateur_alu_unit.sv
// ============================================================================
// Module      : bat_amateur_alu_unit
// Description : Datapath ALU with registered result/flags, OR-muxed bus driver
//               and iterative multiply. Optional divide: define ALU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bat_amateur_alu_unit
    import bat_amateur_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    bat_amateur_alu_if.slave   alu
);

    localparam int C_MSB = WIDTH - 1;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [4:0]       r_iter_op;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_accept;
    logic             w_is_iter;
    logic             w_start;
    logic [WIDTH:0]   w_a_x;
    logic [WIDTH:0]   w_b_x;
    logic [WIDTH:0]   w_cin_x;
    logic [WIDTH:0]   w_tmp;
    logic [WIDTH-1:0] w_val;
    logic             w_c;
    logic             w_v;
    logic             w_upd;
    logic [WIDTH-1:0] w_iter_res;
    logic             w_iter_c;
    logic             w_cin;

`ifdef ALU_DIV_EN
    logic             r_div_zero;
    assign w_is_iter = (alu.ALU_OP == C_OP_MULLO) || (alu.ALU_OP == C_OP_MULHI) ||
                       (alu.ALU_OP == C_OP_DIV)   || (alu.ALU_OP == C_OP_MOD);
`else
    assign w_is_iter = (alu.ALU_OP == C_OP_MULLO) || (alu.ALU_OP == C_OP_MULHI);
`endif

    assign w_accept = alu.ALU_GO && !w_busy;
    assign w_start  = w_accept && w_is_iter;
    assign w_cin    = r_flags[C_FLAG_C];
    assign w_a_x    = {1'b0, alu.A_IN};
    assign w_b_x    = {1'b0, alu.B_IN};
    assign w_cin_x  = {{WIDTH{1'b0}}, w_cin};

    bat_amateur_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clk   (CLK),
        .rst   (RST),
        .start (w_start),
        .op    (alu.ALU_OP),
        .a     (alu.A_IN),
        .b     (alu.B_IN),
        .busy  (w_busy),
        .done  (w_done),
        .lo    (w_lo),
        .hi    (w_hi)
    );

    // Single-cycle ops; w_val is the value Z/N are taken from (for CMP it
    // is the difference, which is never written back).
    always_comb begin
        w_val = r_result;
        w_tmp = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b1;
        case (alu.ALU_OP)
            C_OP_PASSA: w_val = alu.A_IN;
            C_OP_ADD, C_OP_ADC: begin
                w_tmp = w_a_x + w_b_x + ((alu.ALU_OP == C_OP_ADC) ? w_cin_x : {(WIDTH+1){1'b0}});
                w_val = w_tmp[WIDTH-1:0];
                w_c   = w_tmp[WIDTH];
                w_v   = (alu.A_IN[C_MSB] == alu.B_IN[C_MSB]) && (w_val[C_MSB] != alu.A_IN[C_MSB]);
            end
            C_OP_SUB, C_OP_SBB, C_OP_CMP: begin
                w_tmp = w_a_x - w_b_x - ((alu.ALU_OP == C_OP_SBB) ? w_cin_x : {(WIDTH+1){1'b0}});
                w_val = w_tmp[WIDTH-1:0];
                w_c   = w_tmp[WIDTH];
                w_v   = (alu.A_IN[C_MSB] != alu.B_IN[C_MSB]) && (w_val[C_MSB] != alu.A_IN[C_MSB]);
            end
            C_OP_AND:  w_val = alu.A_IN & alu.B_IN;
            C_OP_OR:   w_val = alu.A_IN | alu.B_IN;
            C_OP_XOR:  w_val = alu.A_IN ^ alu.B_IN;
            C_OP_NOTA: w_val = ~alu.A_IN;
            C_OP_INCA: begin
                w_tmp = w_a_x + {{WIDTH{1'b0}}, 1'b1};
                w_val = w_tmp[WIDTH-1:0];
                w_c   = w_tmp[WIDTH];
            end
            C_OP_DECA: begin
                w_tmp = w_a_x - {{WIDTH{1'b0}}, 1'b1};
                w_val = w_tmp[WIDTH-1:0];
                w_c   = w_tmp[WIDTH];
            end
            C_OP_SHL: begin
                w_val = {alu.A_IN[WIDTH-2:0], 1'b0};
                w_c   = alu.A_IN[C_MSB];
            end
            C_OP_SHR: begin
                w_val = {1'b0, alu.A_IN[WIDTH-1:1]};
                w_c   = alu.A_IN[0];
            end
            C_OP_ROL: begin
                w_val = {alu.A_IN[WIDTH-2:0], w_cin};
                w_c   = alu.A_IN[C_MSB];
            end
            C_OP_ROR: begin
                w_val = {w_cin, alu.A_IN[WIDTH-1:1]};
                w_c   = alu.A_IN[0];
            end
            default: w_upd = 1'b0;
        endcase
    end

    always_comb begin
        w_iter_res = (r_iter_op == C_OP_MULHI) ? w_hi : w_lo;
        w_iter_c   = (w_hi != '0);
`ifdef ALU_DIV_EN
        if ((r_iter_op == C_OP_DIV) || (r_iter_op == C_OP_MOD)) begin
            w_iter_res = (r_iter_op == C_OP_MOD) ? w_hi : w_lo;
            w_iter_c   = 1'b0;
            if (r_div_zero) begin
                w_iter_res = '1;
                w_iter_c   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result  <= '0;
            r_flags   <= '0;
            r_iter_op <= '0;
`ifdef ALU_DIV_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            if (w_accept && w_upd) begin
                if (alu.ALU_OP != C_OP_CMP) begin
                    r_result <= w_val;
                end
                r_flags[C_FLAG_Z] <= (w_val == '0);
                r_flags[C_FLAG_C] <= w_c;
                r_flags[C_FLAG_N] <= w_val[C_MSB];
                r_flags[C_FLAG_V] <= w_v;
            end
            if (w_start) begin
                r_iter_op <= alu.ALU_OP;
`ifdef ALU_DIV_EN
                r_div_zero <= (alu.B_IN == '0);
`endif
            end
            if (w_done) begin
                r_result          <= w_iter_res;
                r_flags[C_FLAG_Z] <= (w_iter_res == '0);
                r_flags[C_FLAG_C] <= w_iter_c;
                r_flags[C_FLAG_N] <= w_iter_res[C_MSB];
                r_flags[C_FLAG_V] <= 1'b0;
            end
        end
    end

    always_comb begin
        alu.ALU_REG              = '0;
        alu.ALU_REG[3:0]         = r_flags;
        alu.ALU_REG[C_FLAG_BUSY] = w_busy;
    end

    assign alu.BUS_OUT  = alu.ALU_EN ? r_result : '0;
    assign alu.ALU_BUSY = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_bat_amateur_alu_unit.sv
// ============================================================================
// Module      : tb_bat_amateur_alu_unit
// Description : Self-checking bench: directed scenarios plus random op stream
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bat_amateur_alu_unit;
    import bat_amateur_alu_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m_result;
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    bat_amateur_alu_if #(.WIDTH(WIDTH)) alu_if ();

    bat_amateur_alu_unit #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .alu (alu_if)
    );

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference model: flags packed as {V, N, C, Z}
    task automatic model_exec(input int op, input int a, input int b);
        int  res, full, s, sub, cin, p, val;
        bit  c, v, upd;
        res = int'(m_result);
        cin = int'(m_flags[1]);
        c = 1'b0; v = 1'b0; upd = 1'b1;
        case (op)
            0: res = a;
            1, 2: begin
                full = a + b + ((op == 2) ? cin : 0);
                res  = full % 256;
                c    = (full > 255);
                s    = sgn(a) + sgn(b) + ((op == 2) ? cin : 0);
                v    = (s > 127) || (s < -128);
            end
            3, 4, 15: begin
                sub = b + ((op == 4) ? cin : 0);
                res = (a - sub + 512) % 256;
                c   = (a < sub);
                s   = sgn(a) - sgn(b) - ((op == 4) ? cin : 0);
                v   = (s > 127) || (s < -128);
            end
            5:  res = a & b;
            6:  res = a | b;
            7:  res = a ^ b;
            8:  res = 255 - a;
            9:  begin res = (a + 1) % 256; c = (a == 255); end
            10: begin res = (a + 255) % 256; c = (a == 0); end
            11: begin res = (a * 2) % 256; c = (a >= 128); end
            12: begin res = a / 2; c = (a % 2) == 1; end
            13: begin res = (a * 2) % 256 + cin; c = (a >= 128); end
            14: begin res = a / 2 + cin * 128; c = (a % 2) == 1; end
            16, 17: begin
                p   = a * b;
                res = (op == 16) ? p % 256 : p / 256;
                c   = (p / 256) != 0;
            end
`ifdef ALU_DIV_EN
            18, 19: begin
                if (b == 0) begin res = 255; c = 1'b1; end
                else res = (op == 18) ? a / b : a % b;
            end
`endif
            default: upd = 1'b0;
        endcase
        if (upd) begin
            val = res;
            if (op != 15) m_result = 8'(res);
            m_flags = {v, (val >= 128), c, (val == 0)};
        end
    endtask

    // Issues one op and waits (bounded) until the ALU is idle again.
    task automatic do_op(input int op, input int a, input int b, output bit timed_out);
        timed_out       = 1'b0;
        alu_if.ALU_OP   = 5'(op);
        alu_if.A_IN     = 8'(a);
        alu_if.B_IN     = 8'(b);
        alu_if.ALU_GO   = 1'b1;
        @(posedge clk); #1;
        alu_if.ALU_GO   = 1'b0;
        model_exec(op, a, b);
        for (int i = 0; i < 4 * WIDTH && alu_if.ALU_BUSY; i++) begin
            @(posedge clk); #1;
        end
        if (alu_if.ALU_BUSY) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        bit to;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_result = '0;
        m_flags  = '0;
        checks++; if (alu_if.ALU_REG !== 8'h00) begin errors++; $display("FAIL reset_reg: got %h expected %h", alu_if.ALU_REG, 8'h00); end
        checks++; if (alu_if.BUS_OUT !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h expected %h", alu_if.BUS_OUT, 8'h00); end
        do_op(1, 8'h11, 8'h22, to);
        checks++; if (alu_if.BUS_OUT !== 8'h33) begin errors++; $display("FAIL pre_reset_add: got %h expected %h", alu_if.BUS_OUT, 8'h33); end
        alu_if.ALU_OP = C_OP_MULLO; alu_if.A_IN = 8'h0F; alu_if.B_IN = 8'h0F; alu_if.ALU_GO = 1'b1;
        @(posedge clk); #1;
        alu_if.ALU_GO = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (alu_if.ALU_BUSY !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got %b expected %b", alu_if.ALU_BUSY, 1'b1); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_result = '0;
        m_flags  = '0;
        checks++; if (alu_if.ALU_BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected %b", alu_if.ALU_BUSY, 1'b0); end
        checks++; if (alu_if.BUS_OUT !== 8'h00) begin errors++; $display("FAIL abort_bus: got %h expected %h", alu_if.BUS_OUT, 8'h00); end
        checks++; if (alu_if.ALU_REG !== 8'h00) begin errors++; $display("FAIL abort_reg: got %h expected %h", alu_if.ALU_REG, 8'h00); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (alu_if.BUS_OUT !== 8'h00) begin errors++; $display("FAIL abort_late: got %h expected %h", alu_if.BUS_OUT, 8'h00); end
    endtask

    task automatic test_add_adc();
        bit to;
        do_op(C_OP_ADD, 8'hFF, 8'h01, to);
        checks++; if (alu_if.BUS_OUT !== 8'h00) begin errors++; $display("FAIL add_res: got %h expected %h", alu_if.BUS_OUT, 8'h00); end
        checks++; if (alu_if.ALU_REG !== 8'h03) begin errors++; $display("FAIL add_reg: got %h expected %h", alu_if.ALU_REG, 8'h03); end
        do_op(C_OP_ADC, 8'h00, 8'h00, to);
        checks++; if (alu_if.BUS_OUT !== 8'h01) begin errors++; $display("FAIL adc_res: got %h expected %h", alu_if.BUS_OUT, 8'h01); end
        checks++; if (alu_if.ALU_REG !== 8'h00) begin errors++; $display("FAIL adc_reg: got %h expected %h", alu_if.ALU_REG, 8'h00); end
    endtask

    task automatic test_sub_cmp();
        bit to;
        do_op(C_OP_SUB, 8'h10, 8'h20, to);
        checks++; if (alu_if.BUS_OUT !== 8'hF0) begin errors++; $display("FAIL sub_res: got %h expected %h", alu_if.BUS_OUT, 8'hF0); end
        checks++; if (alu_if.ALU_REG !== 8'h06) begin errors++; $display("FAIL sub_reg: got %h expected %h", alu_if.ALU_REG, 8'h06); end
        do_op(C_OP_CMP, 8'h42, 8'h42, to);
        checks++; if (alu_if.BUS_OUT !== 8'hF0) begin errors++; $display("FAIL cmp_res: got %h expected %h", alu_if.BUS_OUT, 8'hF0); end
        checks++; if (alu_if.ALU_REG !== 8'h01) begin errors++; $display("FAIL cmp_reg: got %h expected %h", alu_if.ALU_REG, 8'h01); end
    endtask

    task automatic test_overflow_rotate();
        bit to;
        do_op(C_OP_ADD, 8'h7F, 8'h01, to);
        checks++; if (alu_if.BUS_OUT !== 8'h80) begin errors++; $display("FAIL ovf_res: got %h expected %h", alu_if.BUS_OUT, 8'h80); end
        checks++; if (alu_if.ALU_REG !== 8'h0C) begin errors++; $display("FAIL ovf_reg: got %h expected %h", alu_if.ALU_REG, 8'h0C); end
        do_op(C_OP_SUB, 8'h00, 8'h01, to);
        do_op(C_OP_ROL, 8'h80, 8'h00, to);
        checks++; if (alu_if.BUS_OUT !== 8'h01) begin errors++; $display("FAIL rol_res: got %h expected %h", alu_if.BUS_OUT, 8'h01); end
        checks++; if (alu_if.ALU_REG !== 8'h02) begin errors++; $display("FAIL rol_reg: got %h expected %h", alu_if.ALU_REG, 8'h02); end
    endtask

    task automatic test_mul();
        bit to;
        alu_if.ALU_OP = C_OP_MULLO; alu_if.A_IN = 8'h12; alu_if.B_IN = 8'h34; alu_if.ALU_GO = 1'b1;
        @(posedge clk); #1;
        alu_if.ALU_GO = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (i == 3) begin
                alu_if.ALU_OP = C_OP_ADD; alu_if.A_IN = 8'h01; alu_if.B_IN = 8'h01; alu_if.ALU_GO = 1'b1;
            end
            checks++; if (alu_if.ALU_BUSY !== 1'b1) begin errors++; $display("FAIL mul_busy_c%0d: got %b expected %b", i, alu_if.ALU_BUSY, 1'b1); end
            @(posedge clk); #1;
            alu_if.ALU_GO = 1'b0;
        end
        model_exec(16, 8'h12, 8'h34);
        checks++; if (alu_if.ALU_BUSY !== 1'b0) begin errors++; $display("FAIL mul_done_busy: got %b expected %b", alu_if.ALU_BUSY, 1'b0); end
        checks++; if (alu_if.BUS_OUT !== 8'hA8) begin errors++; $display("FAIL mullo_res: got %h expected %h", alu_if.BUS_OUT, 8'hA8); end
        checks++; if (alu_if.ALU_REG !== 8'h06) begin errors++; $display("FAIL mullo_reg: got %h expected %h", alu_if.ALU_REG, 8'h06); end
        do_op(C_OP_MULHI, 8'h12, 8'h34, to);
        checks++; if (to) begin errors++; $display("FAIL mulhi_timeout: got busy expected idle"); end
        checks++; if (alu_if.BUS_OUT !== 8'h03) begin errors++; $display("FAIL mulhi_res: got %h expected %h", alu_if.BUS_OUT, 8'h03); end
        checks++; if (alu_if.ALU_REG !== 8'h02) begin errors++; $display("FAIL mulhi_reg: got %h expected %h", alu_if.ALU_REG, 8'h02); end
    endtask

    task automatic test_bus_nop();
        bit to;
        do_op(C_OP_PASSA, 8'h5A, 8'h00, to);
        alu_if.ALU_EN = 1'b0; #1;
        checks++; if (alu_if.BUS_OUT !== 8'h00) begin errors++; $display("FAIL en_off: got %h expected %h", alu_if.BUS_OUT, 8'h00); end
        alu_if.ALU_EN = 1'b1; #1;
        checks++; if (alu_if.BUS_OUT !== 8'h5A) begin errors++; $display("FAIL en_on: got %h expected %h", alu_if.BUS_OUT, 8'h5A); end
        do_op(25, 8'h11, 8'hEE, to);
        checks++; if (alu_if.BUS_OUT !== 8'h5A) begin errors++; $display("FAIL nop_res: got %h expected %h", alu_if.BUS_OUT, 8'h5A); end
        checks++; if (alu_if.ALU_REG !== 8'h00) begin errors++; $display("FAIL nop_reg: got %h expected %h", alu_if.ALU_REG, 8'h00); end
`ifdef ALU_DIV_EN
        do_op(C_OP_DIV, 8'h64, 8'h07, to);
        checks++; if (alu_if.BUS_OUT !== 8'h0E) begin errors++; $display("FAIL div_res: got %h expected %h", alu_if.BUS_OUT, 8'h0E); end
        do_op(C_OP_MOD, 8'h64, 8'h07, to);
        checks++; if (alu_if.BUS_OUT !== 8'h02) begin errors++; $display("FAIL mod_res: got %h expected %h", alu_if.BUS_OUT, 8'h02); end
        do_op(C_OP_DIV, 8'h64, 8'h00, to);
        checks++; if (alu_if.BUS_OUT !== 8'hFF) begin errors++; $display("FAIL div0_res: got %h expected %h", alu_if.BUS_OUT, 8'hFF); end
        checks++; if (alu_if.ALU_REG !== 8'h06) begin errors++; $display("FAIL div0_reg: got %h expected %h", alu_if.ALU_REG, 8'h06); end
`endif
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h7F;
            3: return 8'h80;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_random();
        bit to;
        int op, a, b;
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 31));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, to);
            checks++; if (to) begin errors++; $display("FAIL rnd_timeout op=%0d: got busy expected idle", op); end
            checks++; if (alu_if.BUS_OUT !== m_result) begin errors++; $display("FAIL rnd_res op=%0d a=%h b=%h: got %h expected %h", op, a, b, alu_if.BUS_OUT, m_result); end
            checks++; if (alu_if.ALU_REG !== {4'b0000, m_flags}) begin errors++; $display("FAIL rnd_reg op=%0d a=%h b=%h: got %h expected %h", op, a, b, alu_if.ALU_REG, {4'b0000, m_flags}); end
        end
    endtask

    initial begin
        alu_if.A_IN   = '0;
        alu_if.B_IN   = '0;
        alu_if.ALU_OP = '0;
        alu_if.ALU_GO = 1'b0;
        alu_if.ALU_EN = 1'b1;
        m_result      = '0;
        m_flags       = '0;
        test_reset();
        test_add_adc();
        test_sub_cmp();
        test_overflow_rotate();
        test_mul();
        test_bus_nop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
